// File: rtl/conv_layer_channel_accum.sv
// conv_layer_channel_accum
//   Sums per-input-channel partial feature rows across IN_CHANNELS, adds a
//   per-feature bias, saturates to DATA_WIDTH, optionally applies ReLU, and
//   presents one finished feature row per output handshake.
//
// Ports:
//   clk              clock
//   rst_n            synchronous reset, ACTIVE-HIGH despite the legacy name
//   in_valid/ready   partial-row handshake (in_ready = !out_valid || out_ready)
//   in_row_bus       ARRAY_SIZE lanes of DATA_WIDTH, lane 0 in the MSBs
//   in_feature_idx   feature index of the partial row
//   in_row           row index of the partial row
//   bias             bias for the feature, sampled on the channel-0 accept
//   out_valid/ready  finished-row handshake
//   out_bus          finished row, lane 0 in the MSBs
//   out_feature_idx  feature index captured on channel 0
//   out_row          row index captured on channel 0
//   map_fin          high on the handshake of the last row of the last feature
//   seq_err          sticky: a later channel carried different indices than
//                    channel 0 of the same row
//
// Build option:
//   CONV_ACCUM_RELU_EN  when defined, negative saturated lanes are forced to 0.

module conv_layer_channel_accum #(
  parameter int ARRAY_SIZE   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int IN_CHANNELS  = 3,
  parameter int CH_WIDTH     = 2,
  parameter int OUT_ROWS     = 6,
  parameter int ROW_WIDTH    = 3,
  parameter int TOTAL_WEIGHT = 4,
  parameter int WEIGHT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_row_bus,
  input  logic [WEIGHT_WIDTH-1:0]          in_feature_idx,
  input  logic [ROW_WIDTH-1:0]             in_row,
  input  logic [DATA_WIDTH-1:0]            bias,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_bus,
  output logic [WEIGHT_WIDTH-1:0]          out_feature_idx,
  output logic [ROW_WIDTH-1:0]             out_row,
  output logic                             map_fin,
  output logic                             seq_err
);

  localparam int unsigned LAST_CH = IN_CHANNELS - 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  logic [CH_WIDTH-1:0]             ch_cnt;
  logic signed [ACC_WIDTH-1:0]     acc [ARRAY_SIZE];
  logic signed [ACC_WIDTH-1:0]     sum [ARRAY_SIZE];
  logic [WEIGHT_WIDTH-1:0]         cap_feat;
  logic [ROW_WIDTH-1:0]            cap_row;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] result_bus;

  logic                            accept;
  logic                            first_ch;
  logic                            last_ch;
  logic                            idx_mismatch;
  logic                            handshake;

  logic [DATA_WIDTH-1:0]           lane;
  logic signed [ACC_WIDTH-1:0]     base;
  logic [DATA_WIDTH-1:0]           sat;
  logic [DATA_WIDTH-1:0]           word;

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign handshake    = out_valid && out_ready;
  assign first_ch     = (ch_cnt == '0);
  assign last_ch      = (ch_cnt == CH_WIDTH'(LAST_CH));
  assign idx_mismatch = !first_ch &&
                        ((in_feature_idx != cap_feat) || (in_row != cap_row));

  assign map_fin = handshake &&
                   (out_feature_idx == WEIGHT_WIDTH'(TOTAL_WEIGHT - 1)) &&
                   (out_row == ROW_WIDTH'(OUT_ROWS - 1));

  // Running sum including the presented lane; the bias replaces the stale
  // accumulator on channel 0, so the first and final channel may coincide.
  always_comb begin
    result_bus = '0;
    lane       = '0;
    base       = '0;
    sat        = '0;
    word       = '0;
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      lane   = in_row_bus[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
      base   = first_ch ? sext(bias) : acc[i];
      sum[i] = base + sext(lane);
      if (sum[i] > SAT_MAX) begin
        sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (sum[i] < SAT_MIN) begin
        sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        sat = sum[i][DATA_WIDTH-1:0];
      end
`ifdef CONV_ACCUM_RELU_EN
      word = sat[DATA_WIDTH-1] ? '0 : sat;
`else
      word = sat;
`endif
      result_bus[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] = word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ch_cnt          <= '0;
      for (int unsigned i = 0; i < ARRAY_SIZE; i++) acc[i] <= '0;
      cap_feat        <= '0;
      cap_row         <= '0;
      out_valid       <= 1'b0;
      out_bus         <= '0;
      out_feature_idx <= '0;
      out_row         <= '0;
      seq_err         <= 1'b0;
    end else begin
      if (handshake) out_valid <= 1'b0;
      if (accept) begin
        if (idx_mismatch) seq_err <= 1'b1;
        for (int unsigned i = 0; i < ARRAY_SIZE; i++) acc[i] <= sum[i];
        if (first_ch) begin
          cap_feat <= in_feature_idx;
          cap_row  <= in_row;
        end
        if (last_ch) begin
          // A final accept in the handshake cycle overrides the clear above,
          // keeping out_valid high for back-to-back rows.
          ch_cnt          <= '0;
          out_valid       <= 1'b1;
          out_bus         <= result_bus;
          out_feature_idx <= first_ch ? in_feature_idx : cap_feat;
          out_row         <= first_ch ? in_row : cap_row;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_channel_accum.sv
`timescale 1ns/1ps

module tb_conv_layer_channel_accum;

  localparam int BW = 96;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, map_fin, seq_err;
  logic [BW-1:0] in_row_bus, out_bus;
  logic [1:0]    in_feature_idx, out_feature_idx;
  logic [2:0]    in_row, out_row;
  logic [15:0]   bias;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_map_fin, b_seq_err;
  logic [BW-1:0] b_in_row_bus, b_out_bus;
  logic [1:0]    b_in_feature_idx, b_out_feature_idx;
  logic [2:0]    b_in_row, b_out_row;
  logic [15:0]   b_bias;

  always #5 clk = ~clk;

  conv_layer_channel_accum u_dut (
    .clk(clk), .rst_n(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row_bus(in_row_bus), .in_feature_idx(in_feature_idx), .in_row(in_row),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
    .out_feature_idx(out_feature_idx), .out_row(out_row), .map_fin(map_fin),
    .seq_err(seq_err)
  );

  conv_layer_channel_accum #(.IN_CHANNELS(1), .CH_WIDTH(1)) u_dut_single (
    .clk(clk), .rst_n(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_row_bus(b_in_row_bus), .in_feature_idx(b_in_feature_idx), .in_row(b_in_row),
    .bias(b_bias), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bus(b_out_bus),
    .out_feature_idx(b_out_feature_idx), .out_row(b_out_row), .map_fin(b_map_fin),
    .seq_err(b_seq_err)
  );

  typedef struct {
    logic [BW-1:0] bus;
    logic [1:0]    feat;
    logic [2:0]    row;
    logic          fin;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   fin_pulses = 0;

  function automatic logic [BW-1:0] fill(input logic [15:0] v);
    return {6{v}};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] bus_e, input logic [1:0] f, input logic [2:0] r,
                      input logic fin);
    exp_t e;
    e.bus = bus_e; e.feat = f; e.row = r; e.fin = fin;
    q.push_back(e);
  endtask

  // Presents one partial row and returns at posedge+1 after it was accepted.
  task automatic drive(input logic [BW-1:0] bus_v, input logic [1:0] f, input logic [2:0] r,
                       input logic [15:0] b);
    int w;
    w = 0;
    in_valid = 1'b1; in_row_bus = bus_v; in_feature_idx = f; in_row = r; bias = b;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_row(input logic [15:0] v, input logic [1:0] f, input logic [2:0] r,
                           input logic [15:0] b);
    for (int c = 0; c < 3; c++) drive(fill(v), f, r, b);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 500) begin
      @(posedge clk); #1; w++;
    end
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (map_fin) fin_pulses++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h expected none", out_bus);
        end else begin
          e = q.pop_front();
          chk("out_bus", out_bus, e.bus);
          chk("out_feature_idx", BW'(out_feature_idx), BW'(e.feat));
          chk("out_row", BW'(out_row), BW'(e.row));
          chk("map_fin", BW'(map_fin), BW'(e.fin));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BW-1:0] neg_exp, relu_neg_exp;
`ifdef CONV_ACCUM_RELU_EN
    neg_exp      = fill(16'h0000);
    relu_neg_exp = fill(16'h0000);
`else
    neg_exp      = fill(16'h8000);
    relu_neg_exp = fill(16'hFFE2);
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_row_bus = '0; in_feature_idx = '0; in_row = '0; bias = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_row_bus = '0; b_in_feature_idx = '0; b_in_row = '0; b_bias = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", BW'(out_valid), '0);
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_out_bus", out_bus, '0);
    chk("rst_out_idx", BW'({out_feature_idx, out_row}), '0);
    chk("rst_seq_err", BW'(seq_err), '0);
    chk("rst_map_fin", BW'(map_fin), '0);
    rst = 1'b0;

    // Basic sum + bias, and one-cycle latency after the final accept.
    push(fill(16'h0035), 2'd2, 3'd4, 1'b0);
    drive(fill(16'h0010), 2'd2, 3'd4, 16'h0005);
    drive(fill(16'h0010), 2'd2, 3'd4, 16'h0005);
    chk("latency_before", BW'(out_valid), '0);
    drive(fill(16'h0010), 2'd2, 3'd4, 16'h0005);
    chk("latency_after", BW'(out_valid), BW'(1));

    // Saturation in both directions.
    push(fill(16'h7FFF), 2'd0, 3'd0, 1'b0);
    drive_row(16'h7000, 2'd0, 3'd0, 16'h0000);
    push(neg_exp, 2'd0, 3'd1, 1'b0);
    drive_row(16'h9000, 2'd0, 3'd1, 16'h0000);

    // Lane ordering (lane 0 in MSBs) with a negative bias.
    push({16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, 2'd0, 3'd2, 1'b0);
    drive({16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}, 2'd0, 3'd2, 16'hFFFF);
    drive('0, 2'd0, 3'd2, 16'hFFFF);
    drive('0, 2'd0, 3'd2, 16'hFFFF);

    // Small negative result: -16 -16 + 0 + 2 = -30.
    push(relu_neg_exp, 2'd1, 3'd0, 1'b0);
    drive(fill(16'hFFF0), 2'd1, 3'd0, 16'h0002);
    drive(fill(16'hFFF0), 2'd1, 3'd0, 16'h0002);
    drive(fill(16'h0000), 2'd1, 3'd0, 16'h0002);
    drain();

    // Output stall: held result, input blocked, then release while presenting.
    out_ready = 1'b0;
    push(fill(16'h0300), 2'd1, 3'd1, 1'b0);
    drive_row(16'h0100, 2'd1, 3'd1, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", BW'(in_ready), '0);
      chk("stall_out_bus", out_bus, fill(16'h0300));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", BW'(in_ready), BW'(1));
    push(fill(16'h0003), 2'd1, 3'd2, 1'b0);
    drive_row(16'h0001, 2'd1, 3'd2, 16'h0000);
    drain();
    chk("pre_stream_map_fin", BW'(fin_pulses), '0);

    // Full map: 4 features x 6 rows; lanes r+1 per channel, bias f.
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 6; r++) begin
        push(fill(16'(3*(r+1)+f)), 2'(f), 3'(r), (f == 3 && r == 5));
        drive_row(16'(r+1), 2'(f), 3'(r), 16'(f));
      end
    end
    drain();
    chk("map_fin_count", BW'(fin_pulses), BW'(1));
    chk("seq_err_clean", BW'(seq_err), '0);

    // Sequence error: row index changes mid-row; sum still completes.
    push(fill(16'h0003), 2'd1, 3'd2, 1'b0);
    drive(fill(16'h0001), 2'd1, 3'd2, 16'h0000);
    drive(fill(16'h0001), 2'd1, 3'd3, 16'h0000);
    chk("seq_err_set", BW'(seq_err), BW'(1));
    drive(fill(16'h0001), 2'd1, 3'd2, 16'h0000);
    push(fill(16'h0003), 2'd1, 3'd3, 1'b0);
    drive_row(16'h0001, 2'd1, 3'd3, 16'h0000);
    drain();
    chk("seq_err_sticky", BW'(seq_err), BW'(1));

    // Reset during a partial row discards it.
    drive(fill(16'h0050), 2'd0, 3'd0, 16'h0007);
    drive(fill(16'h0050), 2'd0, 3'd0, 16'h0007);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_seq_err", BW'(seq_err), '0);
    chk("reset_out_valid", BW'(out_valid), '0);
    rst = 1'b0;
    push(fill(16'h0003), 2'd0, 3'd1, 1'b0);
    drive_row(16'h0001, 2'd0, 3'd1, 16'h0000);
    drain();

    // Single-channel instance: every accept is final; back-to-back rows.
    b_out_ready = 1'b1;
    b_bias = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      b_in_valid = 1'b1;
      b_in_row_bus = fill(16'((k+1)*16'h11));
      b_in_feature_idx = 2'(k);
      b_in_row = 3'(k);
      @(posedge clk); #1;
      chk("b2b_out_valid", BW'(b_out_valid), BW'(1));
      chk("b2b_out_bus", b_out_bus, fill(16'((k+1)*16'h11 + 1)));
      chk("b2b_out_idx", BW'({b_out_feature_idx, b_out_row}), BW'({2'(k), 3'(k)}));
    end
    b_out_ready = 1'b0;
    b_in_row_bus = fill(16'h0055);
    b_in_feature_idx = 2'd0;
    b_in_row = 3'd4;
    #1;
    chk("b_stall_in_ready", BW'(b_in_ready), '0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("b_stall_out_bus", b_out_bus, fill(16'h0045));
    end
    b_out_ready = 1'b1;
    #1;
    chk("b_release_in_ready", BW'(b_in_ready), BW'(1));
    @(posedge clk); #1;
    chk("b_release_valid", BW'(b_out_valid), BW'(1));
    chk("b_release_bus", b_out_bus, fill(16'h0056));
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_idle_valid", BW'(b_out_valid), '0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_channel_accum.md
Name: conv_layer_channel_accum

Overview:
- Multi-channel successor stage for the convolution layer: sums per-input-channel partial feature rows from the kernel array across IN_CHANNELS, adds a per-feature bias, saturates, optionally applies ReLU, and emits one finished feature row per output handshake.
- Sits between the kernel array output and the pooling/output buffer.
- Generalises the single-channel conv layer to parametrised channel, row and feature counts, with valid/ready flow control and sequence checking.

Parameters:
- ARRAY_SIZE, 6, lanes per feature row (convolutions computed in parallel).
- DATA_WIDTH, 16, signed two's-complement fixed-point word width.
- ACC_WIDTH, 24, accumulator width per lane; must be >= DATA_WIDTH+CH_WIDTH+1.
- IN_CHANNELS, 3, input channels summed per output row.
- CH_WIDTH, 2, channel counter width.
- OUT_ROWS, 6, rows per feature map.
- ROW_WIDTH, 3, row index width.
- TOTAL_WEIGHT, 4, output features (kernels) per image.
- WEIGHT_WIDTH, 2, feature index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-high reset.
- in_valid  in  1  partial row valid.
- in_ready  out  1  partial row accepted when in_valid && in_ready.
- in_row_bus  in  ARRAY_SIZE*DATA_WIDTH  partial row; lane 0 in the MSBs.
- in_feature_idx  in  WEIGHT_WIDTH  feature of this partial row.
- in_row  in  ROW_WIDTH  row of this partial row.
- bias  in  DATA_WIDTH  bias for in_feature_idx; sampled on channel-0 accept.
- out_valid  out  1  finished row valid.
- out_ready  in  1  downstream accept.
- out_bus  out  ARRAY_SIZE*DATA_WIDTH  finished feature row.
- out_feature_idx  out  WEIGHT_WIDTH  echoed feature index.
- out_row  out  ROW_WIDTH  echoed row index.
- map_fin  out  1  one-cycle pulse on the last row of the last feature.
- seq_err  out  1  sticky index-mismatch flag.

Behaviour:
Reset:
- Reset is synchronous and wins over all other events.
- Reset clears ch_cnt, all accumulator lanes, the captured indices, out_valid, map_fin and seq_err.
- out_bus, out_feature_idx and out_row reset to 0.
- Reset during a partial accumulation discards it; no output is produced for that row.

Input ordering and states:
- Partial rows arrive in order: for each feature, for each row, channels 0..IN_CHANNELS-1 back-to-back.
- Idle vs accumulating is defined by ch_cnt (0 = idle/first channel).

Flow control:
- in_ready = !out_valid || out_ready.
- No input is accepted while a finished row is stalled.

Accumulation (on accept):
- ch_cnt==0: acc[i] = sext(lane i) + sext(bias). Capture in_feature_idx and in_row.
- ch_cnt>0: acc[i] += sext(lane i).
- If in_feature_idx or in_row differs from the captured value, seq_err <= 1 (sticky until reset). Accumulation continues regardless.
- ch_cnt==IN_CHANNELS-1: compute the final sum including the current lane. Load out_bus with the saturated result, out_feature_idx and out_row with the captured indices, and set out_valid <= 1. Reset ch_cnt to 0.
- Otherwise ch_cnt increments.

Latency and output handshake:
- out_valid asserts on the cycle after the final-channel accept.
- Output registers hold stable while out_valid && !out_ready.
- out_valid drops after the handshake unless a new final channel is accepted in the same cycle; in that case out_valid stays 1 with the new data (back-to-back rows).

Saturation (per lane):
- A sum greater than 2^(DATA_WIDTH-1)-1 clamps to 0x7FFF.
- A sum less than -2^(DATA_WIDTH-1) clamps to 0x8000 (values for DATA_WIDTH=16).

map_fin:
- Pulses 1 cycle on the out_valid && out_ready handshake where out_feature_idx==TOTAL_WEIGHT-1 and out_row==OUT_ROWS-1.

IN_CHANNELS=1:
- Every accept is both first and final channel: bias is added and the output is loaded directly.

Optional Feature:
CONV_ACCUM_RELU_EN
- Defined: after saturation, negative lanes are forced to 0 before out_bus is loaded.
- Undefined: the saturated signed value passes through unchanged.
- Timing and handshakes are identical in both builds.

Test Plan:
- IN_CHANNELS=3, all lanes 0x0010 on each channel, bias 0x0005, feature 2, row 4 -> one cycle after the 3rd accept, out_valid=1, every lane 0x0035, out_feature_idx=2, out_row=4.
- Lanes 0x7000 x3 with bias 0 -> all lanes 0x7FFF. Lanes 0x9000 x3 -> 0x8000, or 0x0000 with CONV_ACCUM_RELU_EN.
- Hold out_ready=0 for 5 cycles after a result -> in_ready=0 and out_bus stable. Raise out_ready while the next row's final channel is presented -> the row is accepted that cycle and out_valid stays 1 with the new data.
- Stream 4 features x 6 rows x 3 channels with out_ready=1 -> 24 outputs and exactly one map_fin pulse, coincident with the feature 3, row 5 handshake.
- Channel 1 arrives with in_row=3 after channel 0 with in_row=2 -> seq_err=1 and stays 1 through later correct rows until reset.
- Reset asserted after channel 1 of a row, then a fresh 3-channel row with lanes 0x0001 and bias 0 -> lanes 0x0003, with no stale contribution from the aborted row.
